// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/imem signal bundle for the multi-cycle MIPS sequencer.
// The master modport is the controller side; the slave modport is the datapath side.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       instr_op_i;
    logic             imem_ack_i;
    logic             imem_req_o;
    logic             ir_write_o;
    logic             pc_write_o;
    logic             pc_write_cond_o;
    logic             alu_src_a_o;
    logic [1:0]       alu_src_b_o;
    logic [2:0]       alu_op_o;
    logic             reg_dst_o;
    logic             reg_write_o;
    logic             illegal_o;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] instr_cnt_o;

    modport master (
        input  instr_op_i, imem_ack_i,
        output imem_req_o, ir_write_o, pc_write_o, pc_write_cond_o,
               alu_src_a_o, alu_src_b_o, alu_op_o, reg_dst_o, reg_write_o,
               illegal_o, state_o, instr_cnt_o
    );

    modport slave (
        output instr_op_i, imem_ack_i,
        input  imem_req_o, ir_write_o, pc_write_o, pc_write_cond_o,
               alu_src_a_o, alu_src_b_o, alu_op_o, reg_dst_o, reg_write_o,
               illegal_o, state_o, instr_cnt_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing FSM for the simple MIPS core (R-type, BEQ, ADDI, SLTI).
// Fetches over a req/ack handshake and drives per-state datapath controls.
module multicycle_ctrl #(
    parameter int         CNT_W    = 32,
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_SLTI  = 6'b001010
) (
    input  logic              clk_i,
    input  logic              rst_i,
    multicycle_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXEC_R  = 3'd2,
        WB_R    = 3'd3,
        EXEC_I  = 3'd4,
        WB_I    = 3'd5,
        BRANCH  = 3'd6,
        ILLEGAL = 3'd7
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instrCnt_q, instrCnt_d;

    logic       reqComb;
    logic       irWriteComb;
    logic       pcWriteComb;
    logic       pcWriteCondComb;
    logic       aluSrcAComb;
    logic [1:0] aluSrcBComb;
    logic [2:0] aluOpComb;
    logic       regDstComb;
    logic       regWriteComb;
    logic       illegalComb;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= FETCH;
            instrCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            instrCnt_q <= instrCnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        instrCnt_d      = instrCnt_q;
        reqComb         = 1'b0;
        irWriteComb     = 1'b0;
        pcWriteComb     = 1'b0;
        pcWriteCondComb = 1'b0;
        aluSrcAComb     = 1'b0;
        aluSrcBComb     = 2'b00;
        aluOpComb       = 3'b000;
        regDstComb      = 1'b0;
        regWriteComb    = 1'b0;
        illegalComb     = 1'b0;

        case (state_q)
            FETCH: begin
                reqComb     = 1'b1;
                aluSrcBComb = 2'b01;
                if (bus.imem_ack_i) begin
                    irWriteComb = 1'b1;
                    pcWriteComb = 1'b1;
                    state_d     = DECODE;
                end
            end
            DECODE: begin
                // ALU is idle here, so it precomputes PC+(imm<<2) for a possible branch
                aluSrcBComb = 2'b11;
                case (bus.instr_op_i)
                    OP_RTYPE:         state_d = EXEC_R;
                    OP_ADDI, OP_SLTI: state_d = EXEC_I;
                    OP_BEQ:           state_d = BRANCH;
                    default:          state_d = ILLEGAL;
                endcase
            end
            EXEC_R: begin
                aluSrcAComb = 1'b1;
                aluOpComb   = 3'b010;
                state_d     = WB_R;
            end
            WB_R: begin
                aluSrcAComb  = 1'b1;
                aluOpComb    = 3'b010;
                regDstComb   = 1'b1;
                regWriteComb = 1'b1;
                state_d      = FETCH;
                instrCnt_d   = instrCnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            EXEC_I: begin
                aluSrcAComb = 1'b1;
                aluSrcBComb = 2'b10;
                aluOpComb   = 3'b011;
                state_d     = WB_I;
            end
            WB_I: begin
                aluSrcAComb  = 1'b1;
                aluSrcBComb  = 2'b10;
                aluOpComb    = 3'b011;
                regWriteComb = 1'b1;
                state_d      = FETCH;
                instrCnt_d   = instrCnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            BRANCH: begin
                aluSrcAComb     = 1'b1;
                aluOpComb       = 3'b001;
                pcWriteCondComb = 1'b1;
                state_d         = FETCH;
                instrCnt_d      = instrCnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            ILLEGAL: begin
                illegalComb = 1'b1;
                state_d     = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Controls are gated by reset so nothing writes while reset is held, even in FETCH
    assign bus.imem_req_o      = reqComb         & ~rst_i;
    assign bus.ir_write_o      = irWriteComb     & ~rst_i;
    assign bus.pc_write_o      = pcWriteComb     & ~rst_i;
    assign bus.pc_write_cond_o = pcWriteCondComb & ~rst_i;
    assign bus.alu_src_a_o     = aluSrcAComb     & ~rst_i;
    assign bus.alu_src_b_o     = rst_i ? 2'b00  : aluSrcBComb;
    assign bus.alu_op_o        = rst_i ? 3'b000 : aluOpComb;
    assign bus.reg_dst_o       = regDstComb      & ~rst_i;
    assign bus.reg_write_o     = regWriteComb    & ~rst_i;
    assign bus.illegal_o       = illegalComb     & ~rst_i;
    assign bus.state_o         = state_q;
    assign bus.instr_cnt_o     = instrCnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a 32-bit-counter instance for behaviour and a
// 4-bit-counter instance fed the same inputs to exercise counter wrap.
module tb_multicycle_ctrl;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_LW   = 6'b100011;

    // Packed as {req, irw, pcw, pcc, srcA, srcB[1:0], aluOp[2:0], regDst, regWrite, illegal}
    localparam logic [13:0] CTL_ZERO   = 14'b0;
    localparam logic [13:0] CTL_FETCH  = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0};
    localparam logic [13:0] CTL_FETCHA = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0};
    localparam logic [13:0] CTL_DECODE = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'b000, 1'b0, 1'b0, 1'b0};
    localparam logic [13:0] CTL_EXECR  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0};
    localparam logic [13:0] CTL_WBR    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b010, 1'b1, 1'b1, 1'b0};
    localparam logic [13:0] CTL_EXECI  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b011, 1'b0, 1'b0, 1'b0};
    localparam logic [13:0] CTL_WBI    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b011, 1'b0, 1'b1, 1'b0};
    localparam logic [13:0] CTL_BRANCH = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b001, 1'b0, 1'b0, 1'b0};
    localparam logic [13:0] CTL_ILL    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opDrv;
    logic       ackDrv;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(32)) busMain ();
    multicycle_ctrl_if #(.CNT_W(4))  busNarrow ();

    assign busMain.instr_op_i   = opDrv;
    assign busMain.imem_ack_i   = ackDrv;
    assign busNarrow.instr_op_i = opDrv;
    assign busNarrow.imem_ack_i = ackDrv;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (busMain)
    );

    multicycle_ctrl #(.CNT_W(4)) dutNarrow (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (busNarrow)
    );

    function automatic logic [13:0] ctlVec();
        return {busMain.imem_req_o, busMain.ir_write_o, busMain.pc_write_o,
                busMain.pc_write_cond_o, busMain.alu_src_a_o, busMain.alu_src_b_o,
                busMain.alu_op_o, busMain.reg_dst_o, busMain.reg_write_o, busMain.illegal_o};
    endfunction

    task automatic applyStimulus(input logic [5:0] op, input logic ack);
        opDrv  = op;
        ackDrv = ack;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Checks state, the full control vector and the main counter in one go
    task automatic checkStep(input string tag, input logic [2:0] expState,
                             input logic [13:0] expCtl, input logic [31:0] expCnt);
        checkOutput({tag, ".state"}, {29'b0, busMain.state_o}, {29'b0, expState});
        checkOutput({tag, ".ctl"}, {18'b0, ctlVec()}, {18'b0, expCtl});
        checkOutput({tag, ".cnt"}, busMain.instr_cnt_o, expCnt);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(OP_R, 1'b1);
        #1;
        checkStep("reset", 3'd0, CTL_ZERO, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        checkStep("r.fetch", 3'd0, CTL_FETCHA, 32'd0);
        tick();
        checkStep("r.decode", 3'd1, CTL_DECODE, 32'd0);
        tick();
        checkStep("r.exec", 3'd2, CTL_EXECR, 32'd0);
        tick();
        checkStep("r.wb", 3'd3, CTL_WBR, 32'd0);
        tick();

        applyStimulus(OP_SLTI, 1'b0);
        #1;
        checkStep("slti.wait1", 3'd0, CTL_FETCH, 32'd1);
        tick();
        checkStep("slti.wait2", 3'd0, CTL_FETCH, 32'd1);
        tick();
        checkStep("slti.wait3", 3'd0, CTL_FETCH, 32'd1);
        tick();
        applyStimulus(OP_SLTI, 1'b1);
        #1;
        checkStep("slti.ack", 3'd0, CTL_FETCHA, 32'd1);
        tick();
        applyStimulus(OP_SLTI, 1'b0);
        #1;
        checkStep("slti.decode", 3'd1, CTL_DECODE, 32'd1);
        tick();
        checkStep("slti.exec", 3'd4, CTL_EXECI, 32'd1);
        tick();
        checkStep("slti.wb", 3'd5, CTL_WBI, 32'd1);
        tick();
        checkStep("slti.idle", 3'd0, CTL_FETCH, 32'd2);

        applyStimulus(OP_BEQ, 1'b1);
        #1;
        tick();
        checkStep("beq.decode", 3'd1, CTL_DECODE, 32'd2);
        tick();
        checkStep("beq.branch", 3'd6, CTL_BRANCH, 32'd2);
        tick();
        checkStep("beq.done", 3'd0, CTL_FETCHA, 32'd3);

        applyStimulus(OP_LW, 1'b1);
        tick();
        checkStep("ill.decode", 3'd1, CTL_DECODE, 32'd3);
        tick();
        checkStep("ill.state", 3'd7, CTL_ILL, 32'd3);
        tick();
        checkStep("ill.done", 3'd0, CTL_FETCHA, 32'd3);
        checkOutput("ill.narrowcnt", {28'b0, busNarrow.instr_cnt_o}, 32'd3);

        applyStimulus(OP_ADDI, 1'b1);
        tick();
        tick();
        tick();
        checkStep("addi.wb", 3'd5, CTL_WBI, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        checkStep("midreset", 3'd0, CTL_ZERO, 32'd0);
        checkOutput("midreset.narrowcnt", {28'b0, busNarrow.instr_cnt_o}, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            repeat (4) tick();
            if (i == 14) begin
                checkOutput("wrap.narrow15", {28'b0, busNarrow.instr_cnt_o}, 32'd15);
                checkOutput("wrap.main15", busMain.instr_cnt_o, 32'd15);
            end
        end
        checkOutput("wrap.narrow0", {28'b0, busNarrow.instr_cnt_o}, 32'd0);
        checkStep("wrap.main16", 3'd0, CTL_FETCHA, 32'd16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
